// File: rtl/inst_encoder_pkg.sv
// Shared CPU32 encoding constants: instruction field widths, opcodes the decoder
// executes, and R-type function codes.
package inst_encoder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FUNC_W = 6;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;

  typedef enum logic [OP_W-1:0] {
    OP_R    = 6'h00,
    OP_J    = 6'h02,
    OP_BEQ  = 6'h04,
    OP_BNE  = 6'h05,
    OP_ADDI = 6'h08,
    OP_LW   = 6'h23,
    OP_SW   = 6'h2B
  } opcode_e;

  localparam logic [FUNC_W-1:0] R_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] R_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] R_AND = 6'h24;
  localparam logic [FUNC_W-1:0] R_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] R_SLT = 6'h2A;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field-to-word packer; the opcode case mirrors the decoder so that
// anything the decoder cannot execute is flagged as illegal.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [FUNC_W-1:0] func_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [TGT_W-1:0]  target_i,
  output logic [WORD_W-1:0] word_o,
  output logic              legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (op_i)
      OP_R: begin
        word_o  = {op_i, rs_i, rt_i, rd_i, 5'b0, func_i};
        legal_o = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: begin
        word_o  = {op_i, rs_i, rt_i, imm_i};
        legal_o = 1'b1;
      end
      OP_J: begin
        word_o  = {op_i, target_i};
        legal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// CPU32 program loader: packs field-level instructions and writes them to sequential
// imem addresses. Define INST_ENC_VERIFY_EN to read back and compare each word.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_func,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_WRITE, ST_CHECK, ST_DONE, ST_ERR
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e            state_q;
  logic              ready_q, we_q, done_q, err_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [ADDR_W:0]   count_q;

  logic [WORD_W-1:0] word_c;
  logic              legal_c;
  logic              accept_c;
  logic              word_done_c;

  inst_pack u_pack (
    .op_i     (in_op),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .func_i   (in_func),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (word_c),
    .legal_o  (legal_c)
  );

  assign accept_c = in_valid & ready_q;

  // A word is finished once written (and, with read-back, once it compares equal).
`ifdef INST_ENC_VERIFY_EN
  assign word_done_c = (state_q == ST_CHECK) && (imem_rdata == wdata_q);
`else
  assign word_done_c = (state_q == ST_WRITE);
  logic unused_rdata_c;
  assign unused_rdata_c = ^imem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else if (start) begin
      state_q <= ST_RUN;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= base_addr;
      count_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept_c) begin
            ready_q <= 1'b0;
            last_q  <= in_last;
            if (legal_c) begin
              we_q    <= 1'b1;
              wdata_q <= word_c;
              state_q <= ST_WRITE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
`ifdef INST_ENC_VERIFY_EN
        ST_WRITE: state_q <= ST_CHECK;
        ST_CHECK: begin
          if (imem_rdata != wdata_q) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
`endif
        default: ;
      endcase

      // Advance after a completed word; the top address never wraps.
      if (word_done_c) begin
        count_q <= count_q + (ADDR_W+1)'(1);
        if (last_q) begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
          if (addr_q != ADDR_MAX) addr_q <= addr_q + ADDR_W'(1);
        end else if (addr_q == ADDR_MAX) begin
          err_q   <= 1'b1;
          state_q <= ST_ERR;
        end else begin
          addr_q  <= addr_q + ADDR_W'(1);
          ready_q <= 1'b1;
          state_q <= ST_RUN;
        end
      end
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed programs plus randomized programs
// checked against a program-level model of the loader and an imem model.
`timescale 1ns/1ps
module tb_inst_encoder;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } inst_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_func = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata = '0;
  logic [8:0]  count;
  logic        done, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit corrupt_sw = 1'b0;

  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t cmp_e;
  logic [31:0] mem [0:255];

  inst_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_func(in_func), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Synchronous imem with write-through read; can corrupt read-back of sw words.
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (imem_we && corrupt_sw && imem_wdata[31:26] == 6'h2B) imem_rdata <= 32'h0;
    else imem_rdata <= imem_we ? imem_wdata : mem[imem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
      end else begin
        cmp_e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(cmp_e.addr));
        check("wr_data", 64'(imem_wdata), 64'(cmp_e.data));
      end
      log_q.push_back('{imem_addr, imem_wdata});
    end
  end

  // Returns {legal, word} from the MIPS field layout.
  function automatic logic [32:0] model_encode(input inst_t i);
    logic [31:0] w;
    if (i.op == 6'h00)
      w = (32'(i.op) << 26) | (32'(i.rs) << 21) | (32'(i.rt) << 16) | (32'(i.rd) << 11) | 32'(i.func);
    else if (i.op inside {6'h04, 6'h05, 6'h08, 6'h23, 6'h2B})
      w = (32'(i.op) << 26) | (32'(i.rs) << 21) | (32'(i.rt) << 16) | 32'(i.imm);
    else if (i.op == 6'h02)
      w = (32'(i.op) << 26) | 32'(i.target);
    else
      return {1'b0, 32'h0};
    return {1'b1, w};
  endfunction

  function automatic inst_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [5:0] func, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic last);
    inst_t i;
    i.op = op; i.rs = rs; i.rt = rt; i.rd = rd; i.func = func;
    i.imm = imm; i.target = tgt; i.last = last;
    return i;
  endfunction

  function automatic inst_t rnd_inst(input bit last);
    inst_t i;
    i.rs = 5'($urandom); i.rt = 5'($urandom); i.rd = 5'($urandom);
    i.func = 6'($urandom); i.imm = 16'($urandom); i.target = 26'($urandom);
    i.last = last;
    case ($urandom_range(0, 15))
      0, 1, 2: i.op = 6'h00;
      3, 4:    i.op = 6'h02;
      5, 6:    i.op = 6'h04;
      7, 8:    i.op = 6'h05;
      9, 10:   i.op = 6'h08;
      11, 12:  i.op = 6'h23;
      13, 14:  i.op = 6'h2B;
      default: i.op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
    endcase
    return i;
  endfunction

  task automatic send(input inst_t i);
    int t = 0;
    in_op = i.op; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd; in_func = i.func;
    in_imm = i.imm; in_target = i.target; in_last = i.last; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 64'(t >= 50), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a program at base, feed the instructions the loader will accept, check the end state.
  task automatic run_prog(input logic [7:0] base, input inst_t prog[$], input bit expect_end);
    logic [7:0]  addr = base;
    int          cnt = 0;
    int          t = 0;
    bit          term = 1'b0, exp_done = 1'b0, exp_err = 1'b0, vfail;
    logic [32:0] enc;
    log_q.delete();
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_count", 64'(count), 64'd0);
    check("start_err", 64'(err), 64'd0);
    check("start_done", 64'(done), 64'd0);
    check("start_ready", 64'(in_ready), 64'd1);
    foreach (prog[k]) begin
      if (term) break;
      enc = model_encode(prog[k]);
      vfail = 1'b0;
`ifdef INST_ENC_VERIFY_EN
      vfail = corrupt_sw && (prog[k].op == 6'h2B);
`endif
      if (!enc[32]) begin
        exp_err = 1'b1; term = 1'b1;
      end else begin
        exp_q.push_back('{addr, enc[31:0]});
        if (vfail) begin
          exp_err = 1'b1; term = 1'b1;
        end else begin
          cnt++;
          if (prog[k].last) begin
            exp_done = 1'b1; term = 1'b1;
          end else if (addr == 8'hFF) begin
            exp_err = 1'b1; term = 1'b1;
          end else begin
            addr++;
          end
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(prog[k]);
    end
    if (!expect_end) return;
    while (!(done || err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("end_timeout", 64'(t >= 20), 64'd0);
    repeat (2) @(negedge clk);
    check("end_done", 64'(done), 64'(exp_done));
    check("end_err", 64'(err), 64'(exp_err));
    check("end_count", 64'(count), 64'(cnt));
    check("end_ready", 64'(in_ready), 64'd0);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  inst_t p[$];

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd0);

    // addi rs=1 rt=2 imm=5, last, at base 8
    p.delete();
    p.push_back(mk(6'h08, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b1));
    run_prog(8'd8, p, 1'b1);
    check("lit_addi_addr", 64'(log_q.size() > 0 ? log_q[0].addr : 8'hxx), 64'd8);
    check("lit_addi_data", 64'(log_q.size() > 0 ? log_q[0].data : 32'hx), 64'h20220005);

    // R add then j
    p.delete();
    p.push_back(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0));
    p.push_back(mk(6'h02, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0000010, 1'b1));
    run_prog(8'h10, p, 1'b1);
    check("lit_rj_n", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("lit_add_data", 64'(log_q[0].data), 64'h00221820);
      check("lit_j_addr", 64'(log_q[1].addr), 64'h11);
      check("lit_j_data", 64'(log_q[1].data), 64'h08000010);
    end

    // unsupported opcode
    p.delete();
    p.push_back(mk(6'h3F, 5'd1, 5'd2, 5'd3, 6'h00, 16'h1234, 26'h0, 1'b0));
    run_prog(8'h20, p, 1'b1);
    repeat (5) @(negedge clk);
    check("illegal_nowrite", 64'(log_q.size()), 64'd0);
    check("illegal_ready", 64'(in_ready), 64'd0);

    // no last at the top address: two writes then error, no wrap
    p.delete();
    for (int k = 0; k < 3; k++) p.push_back(mk(6'h08, 5'(k), 5'd4, 5'd0, 6'h00, 16'(k + 1), 26'h0, 1'b0));
    run_prog(8'hFE, p, 1'b1);
    repeat (5) @(negedge clk);
    check("ovf_nwrites", 64'(log_q.size()), 64'd2);
    check("ovf_ready", 64'(in_ready), 64'd0);

    // last on the final address
    p.delete();
    p.push_back(mk(6'h23, 5'd7, 5'd8, 5'd0, 6'h00, 16'hFFFC, 26'h0, 1'b1));
    run_prog(8'hFF, p, 1'b1);

    // restart mid-program
    p.delete();
    p.push_back(mk(6'h05, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010, 26'h0, 1'b0));
    run_prog(8'h40, p, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_count", 64'(count), 64'd1);
    check("mid_ready", 64'(in_ready), 64'd1);
    p.delete();
    p.push_back(mk(6'h04, 5'd5, 5'd6, 5'd0, 6'h00, 16'h8000, 26'h0, 1'b1));
    run_prog(8'h00, p, 1'b1);
    check("restart_addr", 64'(log_q.size() > 0 ? log_q[0].addr : 8'hxx), 64'd0);

`ifdef INST_ENC_VERIFY_EN
    corrupt_sw = 1'b1;
    p.delete();
    p.push_back(mk(6'h2B, 5'd2, 5'd9, 5'd0, 6'h00, 16'h0040, 26'h0, 1'b1));
    run_prog(8'h30, p, 1'b1);
    corrupt_sw = 1'b0;
`endif

    // randomized programs, some placed near the top of memory
    for (int r = 0; r < 40; r++) begin
      int len = $urandom_range(1, 6);
      logic [7:0] b;
      p.delete();
      for (int k = 0; k < len; k++) p.push_back(rnd_inst(k == len - 1));
      b = ($urandom_range(0, 3) == 0) ? 8'(256 - $urandom_range(1, 4)) : 8'($urandom);
      run_prog(b, p, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
